// File: rtl/iob_eth_csr_fifo_port.sv
// CSR-side endpoint that turns NOAUTO CSR write/read strobes into a TX FIFO
// (drained by the Ethernet core) and an RX FIFO (filled by the core).
module iob_eth_csr_fifo_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_n_i,
  input  logic              int_wen_i,
  input  logic [DATA_W-1:0] int_wdata_i,
  output logic              int_ready_wr_o,
  input  logic              int_ren_i,
  output logic [DATA_W-1:0] int_rdata_o,
  output logic              int_rvalid_o,
  output logic              int_ready_rd_o,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_ready_o,
  output logic [ADDR_W:0]   tx_level_o,
  output logic [ADDR_W:0]   rx_level_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];

  logic [ADDR_W-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [ADDR_W:0]   tx_level, rx_level;
  logic              tx_push, tx_pop, rx_push, rx_pop;

  function automatic logic [ADDR_W:0] next_level(input logic [ADDR_W:0] lvl,
                                                 input logic push,
                                                 input logic pop);
    logic [ADDR_W:0] nxt;
    nxt = lvl;
    case ({push, pop})
      2'b10:   nxt = lvl + (ADDR_W + 1)'(1);
      2'b01:   nxt = lvl - (ADDR_W + 1)'(1);
      default: nxt = lvl;
    endcase
    return nxt;
  endfunction

  // Handshakes come only from registered levels, keeping input-to-ready paths out.
  assign int_ready_wr_o = (tx_level != FULL_LEVEL);
  assign tx_valid_o     = (tx_level != '0);
  assign rx_ready_o     = (rx_level != FULL_LEVEL);
  assign int_ready_rd_o = (rx_level != '0);

  assign tx_push = int_wen_i & int_ready_wr_o;
  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign rx_push = rx_valid_i & rx_ready_o;
  assign rx_pop  = int_ren_i & int_ready_rd_o;

  assign tx_data_o  = tx_mem[tx_rptr];
  assign tx_level_o = tx_level;
  assign rx_level_o = rx_level;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_level <= '0;
    end else if (cke_i) begin
      if (tx_push) tx_wptr <= tx_wptr + ADDR_W'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + ADDR_W'(1);
      tx_level <= next_level(tx_level, tx_push, tx_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_wptr      <= '0;
      rx_rptr      <= '0;
      rx_level     <= '0;
      int_rdata_o  <= '0;
      int_rvalid_o <= 1'b0;
    end else if (cke_i) begin
      if (rx_push) rx_wptr <= rx_wptr + ADDR_W'(1);
      if (rx_pop) begin
        rx_rptr     <= rx_rptr + ADDR_W'(1);
        int_rdata_o <= rx_mem[rx_rptr];
      end
      int_rvalid_o <= rx_pop;
      rx_level     <= next_level(rx_level, rx_push, rx_pop);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && cke_i) begin
      if (tx_push) tx_mem[tx_wptr] <= int_wdata_i;
      if (rx_push) rx_mem[rx_wptr] <= rx_data_i;
    end
  end

endmodule

// File: tb/tb_iob_eth_csr_fifo_port.sv
// Self-checking bench for iob_eth_csr_fifo_port: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_iob_eth_csr_fifo_port;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              cke, rst_n;
  logic              wen, ren, tx_ready, rx_valid;
  logic [DATA_W-1:0] wdata, rx_data;
  logic              ready_wr, ready_rd, rvalid, tx_valid, rx_ready;
  logic [DATA_W-1:0] rdata, tx_data;
  logic [ADDR_W:0]   tx_level, rx_level;

  int checks = 0;
  int passed = 0;

  // Reference model: plain queues of words plus the expected read port.
  logic [DATA_W-1:0] tx_q[$];
  logic [DATA_W-1:0] rx_q[$];
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  iob_eth_csr_fifo_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
    .int_wen_i(wen), .int_wdata_i(wdata), .int_ready_wr_o(ready_wr),
    .int_ren_i(ren), .int_rdata_o(rdata), .int_rvalid_o(rvalid),
    .int_ready_rd_o(ready_rd),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .tx_level_o(tx_level), .rx_level_o(rx_level)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit tpush, tpop, rpush, rpop;
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      m_rvalid = 1'b0;
      m_rdata  = '0;
    end else if (cke) begin
      tpush = wen && (tx_q.size() < DEPTH);
      tpop  = tx_ready && (tx_q.size() > 0);
      rpush = rx_valid && (rx_q.size() < DEPTH);
      rpop  = ren && (rx_q.size() > 0);
      m_rvalid = rpop;
      if (rpop) begin
        m_rdata = rx_q[0];
        rx_q.delete(0);
      end
      if (tpop) tx_q.delete(0);
      if (tpush) tx_q.push_back(wdata);
      if (rpush) rx_q.push_back(rx_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 0; ren = 0; tx_ready = 0; rx_valid = 0;
  endtask

  task automatic test_reset();
    cke = 1; rst_n = 0; idle(); wdata = '0; rx_data = '0;
    tick(); tick();
    rst_n = 1;
    checks++; if (ready_wr !== 1'b1) $display("[TB] FAIL reset_ready_wr got %b want 1", ready_wr); else passed++;
    checks++; if (rx_ready !== 1'b1) $display("[TB] FAIL reset_rx_ready got %b want 1", rx_ready); else passed++;
    checks++; if (ready_rd !== 1'b0) $display("[TB] FAIL reset_ready_rd got %b want 0", ready_rd); else passed++;
    checks++; if (tx_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); else passed++;
    checks++; if (tx_level !== 3'd0 || rx_level !== 3'd0)
      $display("[TB] FAIL reset_levels got %0d/%0d want 0/0", tx_level, rx_level); else passed++;
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h0)
      $display("[TB] FAIL reset_read got %b/%h want 0/0", rvalid, rdata); else passed++;
  endtask

  task automatic test_tx_fill_drain();
    logic [DATA_W-1:0] exp_words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    idle();
    wen = 1;
    for (int i = 0; i < 4; i++) begin
      wdata = exp_words[i];
      tick();
    end
    wdata = 32'h55;
    tick();
    wen = 0;
    checks++; if (tx_level !== 3'd4) $display("[TB] FAIL tx_full_level got %0d want 4", tx_level); else passed++;
    checks++; if (ready_wr !== 1'b0) $display("[TB] FAIL tx_full_ready got %b want 0", ready_wr); else passed++;
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_words[i])
        $display("[TB] FAIL tx_drain_%0d got %b/%h want 1/%h", i, tx_valid, tx_data, exp_words[i]); else passed++;
      tick();
    end
    tx_ready = 0;
    checks++; if (tx_valid !== 1'b0 || tx_level !== 3'd0)
      $display("[TB] FAIL tx_empty got %b/%0d want 0/0", tx_valid, tx_level); else passed++;
  endtask

  task automatic test_rx_read();
    idle();
    rx_valid = 1; rx_data = 32'hA5A5A5A5;
    tick();
    rx_valid = 0; ren = 1;
    tick();
    ren = 0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hA5A5A5A5)
      $display("[TB] FAIL rx_read got %b/%h want 1/a5a5a5a5", rvalid, rdata); else passed++;
    tick();
    checks++; if (rvalid !== 1'b0 || rdata !== 32'hA5A5A5A5)
      $display("[TB] FAIL rx_read_hold got %b/%h want 0/a5a5a5a5", rvalid, rdata); else passed++;
  endtask

  task automatic test_read_empty();
    idle();
    ren = 1;
    checks++; if (ready_rd !== 1'b0) $display("[TB] FAIL empty_ready_rd got %b want 0", ready_rd); else passed++;
    tick();
    ren = 0;
    checks++; if (rvalid !== 1'b0 || rx_level !== 3'd0)
      $display("[TB] FAIL empty_read got %b/%0d want 0/0", rvalid, rx_level); else passed++;
  endtask

  task automatic test_full_simultaneous();
    logic [DATA_W-1:0] words [4];
    idle();
    wen = 1;
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      wdata = words[i];
      tick();
    end
    wdata = 32'h66; tx_ready = 1;
    tick();
    checks++; if (tx_level !== 3'd3 || tx_data !== words[1])
      $display("[TB] FAIL full_simul got %0d/%h want 3/%h", tx_level, tx_data, words[1]); else passed++;
    tx_ready = 0;
    tick();
    wen = 0;
    checks++; if (tx_level !== 3'd4 || ready_wr !== 1'b0)
      $display("[TB] FAIL full_refill got %0d/%b want 4/0", tx_level, ready_wr); else passed++;
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_data !== ((i == 3) ? 32'h66 : words[i + 1]))
        $display("[TB] FAIL full_drain_%0d got %h want %h", i, tx_data, (i == 3) ? 32'h66 : words[i + 1]); else passed++;
      tick();
    end
    tx_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] words [3];
    idle();
    rx_valid = 1;
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      rx_data = words[i];
      tick();
    end
    rx_valid = 0; ren = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ren = 0;
      checks++; if (rvalid !== 1'b1 || rdata !== words[i])
        $display("[TB] FAIL b2b_read_%0d got %b/%h want 1/%h", i, rvalid, rdata, words[i]); else passed++;
      tick();
    end
    checks++; if (rvalid !== 1'b0) $display("[TB] FAIL b2b_end got %b want 0", rvalid); else passed++;
  endtask

  task automatic test_cke_and_reset();
    logic [DATA_W-1:0] held;
    idle();
    rx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      rx_data = $urandom;
      tick();
    end
    rx_valid = 0; ren = 1;
    tick();
    held = rdata;
    cke = 0;
    for (int i = 0; i < 5; i++) begin
      wen = 1'($urandom); ren = 1'($urandom); tx_ready = 1'($urandom);
      rx_valid = 1'($urandom); wdata = $urandom; rx_data = $urandom;
      tick();
    end
    checks++; if (rx_level !== 3'd3 || tx_level !== 3'd0)
      $display("[TB] FAIL cke_hold_level got %0d/%0d want 3/0", rx_level, tx_level); else passed++;
    checks++; if (rvalid !== 1'b1 || rdata !== held || held !== m_rdata)
      $display("[TB] FAIL cke_hold_read got %b/%h want 1/%h", rvalid, rdata, m_rdata); else passed++;
    cke = 1; rst_n = 0; idle(); ren = 1;
    tick();
    rst_n = 1; ren = 0;
    checks++; if (rx_level !== 3'd0 || rvalid !== 1'b0)
      $display("[TB] FAIL midreset got %0d/%b want 0/0", rx_level, rvalid); else passed++;
    tick();
    checks++; if (rvalid !== 1'b0) $display("[TB] FAIL midreset_rvalid got %b want 0", rvalid); else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wen      = 1'($urandom);
      ren      = 1'($urandom);
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 2) != 0);
      wdata    = $urandom;
      rx_data  = $urandom;
      cke      = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      tick();
      checks++; if (tx_level !== 3'(tx_q.size()) || rx_level !== 3'(rx_q.size()))
        $display("[TB] FAIL rand_level_%0d got %0d/%0d want %0d/%0d", n, tx_level, rx_level, tx_q.size(), rx_q.size());
      else passed++;
      checks++; if (ready_wr !== (tx_q.size() < DEPTH) || rx_ready !== (rx_q.size() < DEPTH) ||
                    tx_valid !== (tx_q.size() > 0) || ready_rd !== (rx_q.size() > 0))
        $display("[TB] FAIL rand_hs_%0d got %b%b%b%b", n, ready_wr, rx_ready, tx_valid, ready_rd);
      else passed++;
      checks++; if (rvalid !== m_rvalid || rdata !== m_rdata)
        $display("[TB] FAIL rand_read_%0d got %b/%h want %b/%h", n, rvalid, rdata, m_rvalid, m_rdata);
      else passed++;
      if (tx_q.size() > 0) begin
        checks++; if (tx_data !== tx_q[0])
          $display("[TB] FAIL rand_txdata_%0d got %h want %h", n, tx_data, tx_q[0]);
        else passed++;
      end
    end
    cke = 1; rst_n = 1; idle();
  endtask

  initial begin
    test_reset();
    test_tx_fill_drain();
    test_rx_read();
    test_read_empty();
    test_full_simultaneous();
    test_back_to_back();
    test_cke_and_reset();
    test_random();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
